// File: rtl/control_pkg.sv
// Shared types and encodings for the control_unit sequencer: FSM states,
// RV64 opcode/funct constants and ALU opcodes.
package control_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK,
    TRAP
  } state_e;

  // Instruction class, decides which states follow EXECUTE
  typedef enum logic [1:0] {
    K_ALU,
    K_LD,
    K_SD,
    K_BEQ
  } kind_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_DW  = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  function automatic logic f3_is_arith(input logic [2:0] f3);
    return (f3 == F3_ADD) || (f3 == F3_AND) || (f3 == F3_OR);
  endfunction

  function automatic logic [2:0] alu_from_f3(input logic [2:0] f3);
    case (f3)
      F3_AND:  return ALU_AND;
      F3_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_imm_gen.sv
// imm_gen: picks the I/S/B immediate layout from the opcode in ir and
// sign-extends it to WORDSIZE bits (R-type yields 0).
module imm_gen
  import control_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [31:0]         ir,
  output logic [WORDSIZE-1:0] imm
);

  // 13 bits covers the widest (B-type) field, so one extension path serves all
  logic [12:0] raw;
  logic        unused_bits;

  assign unused_bits = ^ir[19:12];

  always_comb begin
    raw = '0;
    case (ir[6:0])
      OP_I, OP_LD: raw = {ir[31], ir[31:20]};
      OP_SD:       raw = {ir[31], ir[31:25], ir[11:7]};
      OP_BEQ:      raw = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default:     raw = '0;
    endcase
  end

  assign imm = {{(WORDSIZE-13){raw[12]}}, raw};

endmodule

// File: rtl/control_unit.sv
// Multi-cycle RV64 control sequencer: fetch/decode/execute/mem/writeback FSM
// owning the pc. Optional retire counter enabled by RETIRE_COUNTER_EN.
module control_unit
  import control_pkg::*;
#(
  parameter int          WORDSIZE = 64,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                alu_zero,
  output logic [WORDSIZE-1:0] pc,
  output logic [4:0]          rf_addr_a,
  output logic [4:0]          rf_addr_b,
  output logic [4:0]          rf_write_addr,
  output logic                rf_write_en,
  output logic [WORDSIZE-1:0] immediate,
  output logic                mux_0_sel,
  output logic                mux_1_sel,
  output logic                mux_2_sel,
  output logic [2:0]          alu_operation,
  output logic                dm_write_en,
  output logic                trap,
  output logic [WORDSIZE-1:0] retired_count
);

  state_e              state_reg;
  kind_e               kind_reg;
  logic [31:0]         ir_reg;
  logic [WORDSIZE-1:0] pc_reg;
  logic [WORDSIZE-1:0] imm_reg;
  logic [4:0]          addr_a_reg, addr_b_reg, rd_reg;
  logic                rf_we_reg, dm_we_reg, mux_1_reg, mux_2_reg, trap_reg;
  logic [2:0]          alu_op_reg;

  logic [WORDSIZE-1:0] imm_value;
  logic                dec_legal, dec_mux1;
  kind_e               dec_kind;
  logic [2:0]          dec_op;

  imm_gen #(.WORDSIZE(WORDSIZE)) u_imm_gen (
    .ir  (ir_reg),
    .imm (imm_value)
  );

  always_comb begin
    dec_legal = 1'b0;
    dec_kind  = K_ALU;
    dec_op    = ALU_ADD;
    dec_mux1  = 1'b0;
    case (ir_reg[6:0])
      OP_R: begin
        dec_mux1 = 1'b1;
        if (ir_reg[31:25] == F7_BASE && f3_is_arith(ir_reg[14:12])) begin
          dec_legal = 1'b1;
          dec_op    = alu_from_f3(ir_reg[14:12]);
        end else if (ir_reg[31:25] == F7_SUB && ir_reg[14:12] == F3_ADD) begin
          dec_legal = 1'b1;
          dec_op    = ALU_SUB;
        end
      end
      OP_I: begin
        dec_legal = f3_is_arith(ir_reg[14:12]);
        dec_op    = alu_from_f3(ir_reg[14:12]);
      end
      OP_LD: begin
        dec_legal = (ir_reg[14:12] == F3_DW);
        dec_kind  = K_LD;
      end
      OP_SD: begin
        dec_legal = (ir_reg[14:12] == F3_DW);
        dec_kind  = K_SD;
      end
      OP_BEQ: begin
        dec_legal = (ir_reg[14:12] == F3_BEQ);
        dec_kind  = K_BEQ;
        dec_op    = ALU_SUB;
        dec_mux1  = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Outputs are registered on entry to the state in which they must be seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= FETCH;
      kind_reg   <= K_ALU;
      ir_reg     <= '0;
      pc_reg     <= RESET_PC[WORDSIZE-1:0];
      imm_reg    <= '0;
      addr_a_reg <= '0;
      addr_b_reg <= '0;
      rd_reg     <= '0;
      rf_we_reg  <= 1'b0;
      dm_we_reg  <= 1'b0;
      mux_1_reg  <= 1'b0;
      mux_2_reg  <= 1'b0;
      alu_op_reg <= ALU_ADD;
      trap_reg   <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (instr_valid) begin
            ir_reg    <= instr;
            state_reg <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            addr_a_reg <= ir_reg[19:15];
            addr_b_reg <= ir_reg[24:20];
            rd_reg     <= ir_reg[11:7];
            imm_reg    <= imm_value;
            kind_reg   <= dec_kind;
            alu_op_reg <= dec_op;
            mux_1_reg  <= dec_mux1;
            state_reg  <= EXECUTE;
          end else begin
            trap_reg  <= 1'b1;
            state_reg <= TRAP;
          end
        end
        EXECUTE: begin
          case (kind_reg)
            K_BEQ: begin
              pc_reg    <= alu_zero ? pc_reg + imm_reg : pc_reg + WORDSIZE'(4);
              mux_1_reg <= 1'b0;
              state_reg <= FETCH;
            end
            K_LD: state_reg <= MEM;
            K_SD: begin
              dm_we_reg <= 1'b1;
              state_reg <= MEM;
            end
            default: begin
              rf_we_reg <= (rd_reg != 5'd0);
              mux_2_reg <= 1'b0;
              state_reg <= WRITEBACK;
            end
          endcase
        end
        MEM: begin
          if (kind_reg == K_SD) begin
            dm_we_reg <= 1'b0;
            mux_1_reg <= 1'b0;
            pc_reg    <= pc_reg + WORDSIZE'(4);
            state_reg <= FETCH;
          end else begin
            rf_we_reg <= (rd_reg != 5'd0);
            mux_2_reg <= 1'b1;
            state_reg <= WRITEBACK;
          end
        end
        WRITEBACK: begin
          rf_we_reg <= 1'b0;
          mux_1_reg <= 1'b0;
          mux_2_reg <= 1'b0;
          pc_reg    <= pc_reg + WORDSIZE'(4);
          state_reg <= FETCH;
        end
        TRAP:    state_reg <= TRAP;
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign instr_ready   = (state_reg == FETCH);
  assign pc            = pc_reg;
  assign rf_addr_a     = addr_a_reg;
  assign rf_addr_b     = addr_b_reg;
  assign rf_write_addr = rd_reg;
  assign rf_write_en   = rf_we_reg;
  assign immediate     = imm_reg;
  assign mux_0_sel     = 1'b0;
  assign mux_1_sel     = mux_1_reg;
  assign mux_2_sel     = mux_2_reg;
  assign alu_operation = alu_op_reg;
  assign dm_write_en   = dm_we_reg;
  assign trap          = trap_reg;

`ifdef RETIRE_COUNTER_EN
  logic [WORDSIZE-1:0] retired_reg;
  logic                retire;

  assign retire = (state_reg == WRITEBACK)
               || (state_reg == EXECUTE && kind_reg == K_BEQ)
               || (state_reg == MEM && kind_reg == K_SD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_reg <= '0;
    end else if (retire) begin
      retired_reg <= retired_reg + WORDSIZE'(1);
    end
  end

  assign retired_count = retired_reg;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: ALU/LD/SD/BEQ sequencing, traps and
// asynchronous reset abort, checked with immediate assertions.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_zero;
  logic [63:0] pc;
  logic [4:0]  rf_addr_a, rf_addr_b, rf_write_addr;
  logic        rf_write_en;
  logic [63:0] immediate;
  logic        mux_0_sel, mux_1_sel, mux_2_sel;
  logic [2:0]  alu_operation;
  logic        dm_write_en;
  logic        trap;
  logic [63:0] retired_count;

  int          cmp_count = 0;
  int          err_count = 0;
  logic [63:0] exp_pc;
  logic [63:0] exp_ret;

  control_unit #(.WORDSIZE(64), .RESET_PC(64'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .alu_zero      (alu_zero),
    .pc            (pc),
    .rf_addr_a     (rf_addr_a),
    .rf_addr_b     (rf_addr_b),
    .rf_write_addr (rf_write_addr),
    .rf_write_en   (rf_write_en),
    .immediate     (immediate),
    .mux_0_sel     (mux_0_sel),
    .mux_1_sel     (mux_1_sel),
    .mux_2_sel     (mux_2_sel),
    .alu_operation (alu_operation),
    .dm_write_en   (dm_write_en),
    .trap          (trap),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic retire_one();
`ifdef RETIRE_COUNTER_EN
    exp_ret = exp_ret + 64'd1;
`endif
    chk("retired_count", retired_count, exp_ret);
  endtask

  // Called at a negedge in FETCH; returns at the negedge in DECODE
  task automatic issue(input logic [31:0] w);
    chk("ready_in_fetch", instr_ready, 1'b1);
    instr       = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = '0;
    chk("ready_in_decode", instr_ready, 1'b0);
    chk("trap_in_decode", trap, 1'b0);
  endtask

  task automatic run_alu(input logic [31:0] w, input logic [4:0] ra, input logic [4:0] rb,
                         input logic [4:0] rd, input logic [63:0] imm, input logic mux1,
                         input logic [2:0] op, input logic we);
    issue(w);
    @(negedge clk);
    chk("ex_addr_a", rf_addr_a, ra);
    if (mux1) chk("ex_addr_b", rf_addr_b, rb);
    chk("ex_mux_1", mux_1_sel, mux1);
    chk("ex_alu_op", alu_operation, op);
    chk("ex_imm", immediate, imm);
    chk("ex_rf_we", rf_write_en, 1'b0);
    @(negedge clk);
    chk("wb_rf_we", rf_write_en, we);
    chk("wb_rd", rf_write_addr, rd);
    chk("wb_mux_2", mux_2_sel, 1'b0);
    chk("wb_mux_1", mux_1_sel, mux1);
    chk("wb_alu_op", alu_operation, op);
    chk("wb_pc_held", pc, exp_pc);
    @(negedge clk);
    exp_pc = exp_pc + 64'd4;
    chk("fetch_rf_we_off", rf_write_en, 1'b0);
    chk("fetch_pc", pc, exp_pc);
    chk("fetch_ready", instr_ready, 1'b1);
    retire_one();
    $display("ALU instr=%08h pc=%0h we=%0b", w, pc, we);
  endtask

  task automatic run_beq(input logic z);
    issue(32'hFE000CE3);
    @(negedge clk);
    alu_zero = z;
    chk("beq_alu_op", alu_operation, 3'b001);
    chk("beq_mux_1", mux_1_sel, 1'b1);
    chk("beq_imm", immediate, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("beq_pc_held", pc, exp_pc);
    @(negedge clk);
    alu_zero = 1'b0;
    exp_pc = z ? exp_pc - 64'd8 : exp_pc + 64'd4;
    chk("beq_ready_lat3", instr_ready, 1'b1);
    chk("beq_pc", pc, exp_pc);
    chk("beq_mux_1_off", mux_1_sel, 1'b0);
    retire_one();
    $display("BEQ zero=%0b pc=%0h", z, pc);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    exp_pc  = 64'd0;
    exp_ret = 64'd0;
    chk("rst_trap", trap, 1'b0);
    chk("rst_pc", pc, exp_pc);
    chk("rst_ready", instr_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    $display("RESET pulse pc=%0h trap=%0b", pc, trap);
  endtask

  initial begin
    rst_n       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    alu_zero    = 1'b0;
    exp_pc      = 64'd0;
    exp_ret     = 64'd0;
    repeat (2) @(negedge clk);
    chk("reset_pc", pc, 64'd0);
    chk("reset_trap", trap, 1'b0);
    chk("reset_rf_we", rf_write_en, 1'b0);
    chk("reset_dm_we", dm_write_en, 1'b0);
    chk("reset_imm", immediate, 64'd0);
    chk("reset_mux", {mux_0_sel, mux_1_sel, mux_2_sel}, 3'b000);
    chk("reset_alu_op", alu_operation, 3'b000);
    chk("reset_retired", retired_count, 64'd0);
    rst_n = 1'b1;
    $display("RESET released pc=%0h", pc);

    // addi x1,x0,5 ; add x3,x1,x2 ; sub ; or ; andi -1 ; addi x0 (write suppressed)
    run_alu(32'h00500093, 5'd0, 5'd0, 5'd1, 64'd5, 1'b0, 3'b000, 1'b1);
    run_alu(32'h002081B3, 5'd1, 5'd2, 5'd3, 64'd0, 1'b1, 3'b000, 1'b1);
    run_alu(32'h402082B3, 5'd1, 5'd2, 5'd5, 64'd0, 1'b1, 3'b001, 1'b1);
    run_alu(32'h0020E333, 5'd1, 5'd2, 5'd6, 64'd0, 1'b1, 3'b011, 1'b1);
    run_alu(32'hFFF0F393, 5'd1, 5'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b010, 1'b1);
    run_alu(32'h00100013, 5'd0, 5'd0, 5'd0, 64'd1, 1'b0, 3'b000, 1'b0);

    // sd x3,8(x1)
    issue(32'h0030B423);
    @(negedge clk);
    chk("sd_ex_addr_a", rf_addr_a, 5'd1);
    chk("sd_ex_addr_b", rf_addr_b, 5'd3);
    chk("sd_ex_alu_op", alu_operation, 3'b000);
    chk("sd_ex_mux_1", mux_1_sel, 1'b0);
    chk("sd_ex_dm_we", dm_write_en, 1'b0);
    @(negedge clk);
    chk("sd_mem_dm_we", dm_write_en, 1'b1);
    chk("sd_mem_imm", immediate, 64'd8);
    chk("sd_mem_rf_we", rf_write_en, 1'b0);
    chk("sd_mem_pc_held", pc, exp_pc);
    @(negedge clk);
    exp_pc = exp_pc + 64'd4;
    chk("sd_fetch_dm_we", dm_write_en, 1'b0);
    chk("sd_fetch_rf_we", rf_write_en, 1'b0);
    chk("sd_ready_lat4", instr_ready, 1'b1);
    chk("sd_pc", pc, exp_pc);
    retire_one();
    $display("SD pc=%0h", pc);

    // ld x4,8(x1)
    issue(32'h0080B203);
    @(negedge clk);
    chk("ld_ex_imm", immediate, 64'd8);
    chk("ld_ex_alu_op", alu_operation, 3'b000);
    @(negedge clk);
    chk("ld_mem_rf_we", rf_write_en, 1'b0);
    chk("ld_mem_dm_we", dm_write_en, 1'b0);
    @(negedge clk);
    chk("ld_wb_mux_2", mux_2_sel, 1'b1);
    chk("ld_wb_rd", rf_write_addr, 5'd4);
    chk("ld_wb_rf_we", rf_write_en, 1'b1);
    chk("ld_wb_ready", instr_ready, 1'b0);
    @(negedge clk);
    exp_pc = exp_pc + 64'd4;
    chk("ld_ready_lat5", instr_ready, 1'b1);
    chk("ld_fetch_rf_we", rf_write_en, 1'b0);
    chk("ld_fetch_mux_2", mux_2_sel, 1'b0);
    chk("ld_pc", pc, exp_pc);
    retire_one();
    $display("LD pc=%0h", pc);

    run_beq(1'b1);
    run_beq(1'b0);

    // Unused opcode traps permanently, even with valid words offered
    issue(32'h0000007F);
    @(negedge clk);
    chk("trap_set", trap, 1'b1);
    chk("trap_ready", instr_ready, 1'b0);
    instr       = 32'h00500093;
    instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    instr_valid = 1'b0;
    chk("trap_sticky", trap, 1'b1);
    chk("trap_ready_held", instr_ready, 1'b0);
    chk("trap_pc_frozen", pc, exp_pc);
    chk("trap_rf_we", rf_write_en, 1'b0);
    $display("TRAP opcode=7f pc=%0h trap=%0b", pc, trap);

    reset_pulse();

    // Unknown funct7 on an R-type traps as well
    issue(32'h022081B3);
    @(negedge clk);
    chk("funct_trap", trap, 1'b1);
    chk("funct_trap_ready", instr_ready, 1'b0);
    $display("TRAP funct7=01 trap=%0b", trap);

    reset_pulse();

    // Reset asserted in EXECUTE of an addi aborts it
    issue(32'h00500093);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_pc", pc, 64'd0);
    chk("abort_trap", trap, 1'b0);
    chk("abort_imm", immediate, 64'd0);
    chk("abort_ready", instr_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_write", rf_write_en, 1'b0);
      chk("abort_idle_fetch", instr_ready, 1'b1);
    end
    chk("abort_pc_after", pc, 64'd0);
    chk("abort_retired", retired_count, 64'd0);
    $display("ABORT pc=%0h rf_we=%0b", pc, rf_write_en);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle control sequencer for the RV64 datapath. It fetches 32-bit instructions over a valid/ready handshake, decodes them, and drives every datapath control input: register-file addresses and write enable, immediate, three mux selects, ALU operation and data-memory write enable.
It also owns the program counter and resolves BEQ using the datapath's ALU zero flag.
Supported instructions: ADD, SUB, AND, OR, ADDI, ANDI, ORI, LD, SD, BEQ. Anything else traps.

Parameters:
WORDSIZE, 64, datapath word width; width of immediate and pc.
RESET_PC, 0, pc value after reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
instr  input  32  instruction word; sampled on the handshake.
instr_valid  input  1  instruction source has a word for the current pc.
instr_ready  output  1  sequencer accepts an instruction this cycle.
alu_zero  input  1  high when the datapath alu_result is 0.
pc  output  WORDSIZE  address of the current/next instruction.
rf_addr_a  output  5  register-file read address A.
rf_addr_b  output  5  register-file read address B.
rf_write_addr  output  5  register-file write address.
rf_write_en  output  1  register-file write strobe.
immediate  output  WORDSIZE  sign-extended immediate.
mux_0_sel  output  1  ALU A select: 0 = rf_data_a, 1 = rf_data_b.
mux_1_sel  output  1  ALU B select: 0 = immediate, 1 = rf_data_b.
mux_2_sel  output  1  write-back select: 0 = alu_result, 1 = dm_data_output.
alu_operation  output  3  ALU opcode: ADD=000, SUB=001, AND=010, OR=011.
dm_write_en  output  1  data-memory write strobe.
trap  output  1  sticky illegal-instruction flag.
retired_count  output  WORDSIZE  retired instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, pc=RESET_PC, ir=0, trap=0, retired_count=0.
  - All strobes 0; all address, immediate, select and opcode outputs 0.
  - Asserting rst_n=0 mid-instruction aborts that instruction; no partial write issues after release.
- FETCH:
  - instr_ready=1.
  - On instr_valid=1: latch ir and go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Register rd/rs1/rs2, the immediate and the ALU op from ir.
  - Immediate generation, sign-extended to WORDSIZE:
    - I-type: ir[31:20].
    - S-type: {ir[31:25],ir[11:7]}.
    - B-type: {ir[31],ir[7],ir[30:25],ir[11:8],1'b0}.
  - Unknown opcode or funct field: go to TRAP.
- EXECUTE:
  - rf_addr_a=rs1, rf_addr_b=rs2, mux_0_sel=0.
  - R-type: mux_1_sel=1. I-type, LD, SD: mux_1_sel=0, alu_operation=ADD for LD/SD.
  - BEQ: mux_1_sel=1, alu_operation=SUB. alu_zero is sampled at the end of this cycle:
    - taken: pc<=pc+immediate;
    - not taken: pc<=pc+4;
    - then go to FETCH.
  - LD/SD go to MEM. ALU ops go to WRITEBACK.
- MEM:
  - Addresses and ALU controls held from EXECUTE.
  - SD: dm_write_en=1 for exactly this cycle, pc<=pc+4, then FETCH.
  - LD: go to WRITEBACK.
- WRITEBACK:
  - Controls held from EXECUTE; mux_2_sel=1 for LD, 0 otherwise.
  - rf_write_en=1 for exactly one cycle, suppressed when rd=0.
  - rf_write_addr=rd; pc<=pc+4; then FETCH.
- TRAP:
  - trap=1 and stays 1 until reset.
  - instr_ready=0, all strobes 0, pc frozen.
- Latency from handshake cycle to next FETCH: ALU = 4 cycles, LD = 5, SD = 4, BEQ = 3.
- Outside the states listed above, all strobes and selects are 0.
- pc arithmetic is modulo 2^WORDSIZE; wrap-around is silent.
- pc is updated only at instruction retirement (the last state of the instruction).

Optional Feature:
RETIRE_COUNTER_EN:
- Defined: retired_count increments by 1 in the final cycle of every retired instruction, including a BEQ in EXECUTE and an SD in MEM. It wraps modulo 2^WORDSIZE.
- Undefined: retired_count is tied to 0 and no counter register exists.

Decomposition:
- Package control_pkg holds:
  - state enum {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP};
  - opcode constants (OP_R=0110011, OP_I=0010011, OP_LD=0000011, OP_SD=0100011, OP_BEQ=1100011);
  - ALU opcode constants.
- One sub-module, imm_gen: combinational format select plus sign extension from ir.

Test Plan:
1. Reset, then instr=0x00500093 (addi x1,x0,5) -> in WRITEBACK: rf_write_addr=1, immediate=5, mux_1_sel=0, alu_operation=000, rf_write_en=1 for one cycle; pc 0->4.
2. instr=0x002081B3 (add x3,x1,x2) -> EXECUTE: rf_addr_a=1, rf_addr_b=2, mux_1_sel=1; WRITEBACK: rf_write_addr=3, mux_2_sel=0.
3. instr=0x0030B423 (sd x3,8(x1)) -> MEM: immediate=8, dm_write_en=1 for one cycle, rf_write_en never asserted; pc+=4.
4. instr=0x0080B203 (ld x4,8(x1)) -> WRITEBACK in cycle 5: mux_2_sel=1, rf_write_addr=4, rf_write_en=1.
5. BEQ with offset -8 (instr=0xFE000CE3): alu_zero=1 -> pc becomes pc-8; alu_zero=0 -> pc+4. Latency 3 cycles in both cases.
6. Unused opcode 0x0000007F -> trap=1 and instr_ready=0 permanently. Then rst_n pulse mid-EXECUTE of an addi -> no rf_write_en, pc=RESET_PC, trap=0.
